// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM state, error-code and scan-code constants for the PS/2 receiver
package ps2_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t DATA   = 2'd1;
    localparam state_t PARITY = 2'd2;
    localparam state_t STOP   = 2'd3;
    localparam logic [1:0] ERR_START   = 2'd0;
    localparam logic [1:0] ERR_PARITY  = 2'd1;
    localparam logic [1:0] ERR_STOP    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser followed by a saturating-count glitch filter
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic filt
);
    logic s1, s2;
    logic [7:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            filt <= 1'b1;
            cnt  <= 8'd0;
        end else begin
            s1 <= line;
            s2 <= s1;
            if (s2 == filt) begin
                cnt <= 8'd0;
            end else if (cnt == 8'(FILTER_LEN - 1)) begin
                filt <= s2;
                cnt  <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: filtered PS/2 device-to-host frame receiver with error reporting and prefix decode
module ps2_frame_receiver import ps2_pkg::*; #(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int FILTER_LEN    = 8,
    parameter int TIMEOUT_US    = 200,
    parameter int DECODE_PREFIX = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ps2_received_data,
    output logic       ps2_received_data_strb,
    output logic       ps2_break,
    output logic       ps2_extended,
    output logic       ps2_frame_err,
    output logic [1:0] ps2_err_code
);
    localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    logic fc, fd, fc_d, fall;
    state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic par_ok, break_pend, ext_pend;
    logic [31:0] tcnt;
    logic timeout, start_e, stop_e, par_e, err_now, done, is_brk, is_ext, strb_now;
    logic [1:0] code_now;
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (.clk(clk), .rst(rst), .line(ps2_clk), .filt(fc));
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (.clk(clk), .rst(rst), .line(ps2_data), .filt(fd));
    assign fall     = fc_d & ~fc;
    // an edge landing on the terminal count takes priority over the timeout
    assign timeout  = (state != IDLE) && !fall && (tcnt == 32'(TIMEOUT_CYCLES));
    assign start_e  = fall && state == IDLE && fd;
    assign stop_e   = fall && state == STOP && !fd;
    assign par_e    = fall && state == STOP && fd && !par_ok;
    assign err_now  = start_e | stop_e | par_e | timeout;
    assign code_now = timeout ? ERR_TIMEOUT : stop_e ? ERR_STOP : par_e ? ERR_PARITY : ERR_START;
    assign done     = fall && state == STOP && fd && par_ok;
    assign is_brk   = (DECODE_PREFIX != 0) && shreg == SC_BREAK;
    assign is_ext   = (DECODE_PREFIX != 0) && shreg == SC_EXT;
    assign strb_now = done && !is_brk && !is_ext;
    always_ff @(posedge clk) begin
        if (rst) begin
            fc_d                   <= 1'b1;
            state                  <= IDLE;
            bit_cnt                <= 3'd0;
            shreg                  <= 8'h00;
            par_ok                 <= 1'b0;
            break_pend             <= 1'b0;
            ext_pend               <= 1'b0;
            tcnt                   <= 32'd0;
            ps2_received_data      <= 8'h00;
            ps2_received_data_strb <= 1'b0;
            ps2_break              <= 1'b0;
            ps2_extended           <= 1'b0;
            ps2_frame_err          <= 1'b0;
            ps2_err_code           <= 2'd0;
        end else begin
            fc_d                   <= fc;
            ps2_received_data_strb <= strb_now;
            ps2_frame_err          <= err_now;
            if (err_now) ps2_err_code <= code_now;
            if (strb_now) begin
                ps2_received_data <= shreg;
                ps2_break         <= break_pend;
                ps2_extended      <= ext_pend;
            end
            break_pend <= (err_now || strb_now) ? 1'b0 : (done && is_brk) ? 1'b1 : break_pend;
            ext_pend   <= (err_now || strb_now) ? 1'b0 : (done && is_ext) ? 1'b1 : ext_pend;
            tcnt       <= (state == IDLE || fall || timeout) ? 32'd0 : tcnt + 32'd1;
            if (timeout) begin
                state <= IDLE;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!fd) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shreg   <= {fd, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_ok <= ^{shreg, fd};
                        state  <= STOP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb_ps2_frame_receiver: table-driven frame checks plus timeout, glitch and reset sequences
`timescale 1ns/1ps
module tb_ps2_frame_receiver;
    logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] m_data, r_data, f_data;
    logic m_strb, m_brk, m_ext, m_err, r_strb, r_brk, r_ext, r_err, f_strb, f_brk, f_ext, f_err;
    logic [1:0] m_code, r_code, f_code;
    int total = 0, bad = 0;
    int ms = 0, me = 0, rs = 0, re = 0, fe = 0, both = 0;
    always #250 clk = ~clk;
    ps2_frame_receiver #(.CLK_FREQ_HZ(2_000_000), .FILTER_LEN(8), .TIMEOUT_US(200), .DECODE_PREFIX(1)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ps2_received_data(m_data),
        .ps2_received_data_strb(m_strb), .ps2_break(m_brk), .ps2_extended(m_ext), .ps2_frame_err(m_err), .ps2_err_code(m_code));
    ps2_frame_receiver #(.CLK_FREQ_HZ(2_000_000), .FILTER_LEN(8), .TIMEOUT_US(200), .DECODE_PREFIX(0)) dut_raw (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ps2_received_data(r_data),
        .ps2_received_data_strb(r_strb), .ps2_break(r_brk), .ps2_extended(r_ext), .ps2_frame_err(r_err), .ps2_err_code(r_code));
    ps2_frame_receiver #(.CLK_FREQ_HZ(2_000_000), .FILTER_LEN(2), .TIMEOUT_US(200), .DECODE_PREFIX(1)) dut_f2 (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ps2_received_data(f_data),
        .ps2_received_data_strb(f_strb), .ps2_break(f_brk), .ps2_extended(f_ext), .ps2_frame_err(f_err), .ps2_err_code(f_code));
    always @(negedge clk) begin
        if (m_strb) ms++;
        if (m_err) me++;
        if (r_strb) rs++;
        if (r_err) re++;
        if (f_err) fe++;
        if ((m_strb && m_err) || (r_strb && r_err)) both++;
    end
    typedef struct {
        logic [7:0] d;
        logic       pbad;
        int         ms;
        logic [7:0] md;
        logic       mb;
        logic       me;
        int         merr;
        int         mcode;
        int         rs;
    } vec_t;
    vec_t v[8];
    task automatic chk(input string n, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", n, idx, act, exp);
        end
    endtask
    // device drives data while the clock is high; optional 1.5 us low glitch mid-high
    task automatic send(input logic [7:0] d, input logic pflip, input int nb, input logic gl);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ pflip, d, 1'b0};
        for (int i = 0; i < nb; i++) begin
            ps2_data = f[i];
            if (gl) begin
                #20000 ps2_clk = 1'b0;
                #1500 ps2_clk = 1'b1;
                #18500;
            end else begin
                #40000;
            end
            ps2_clk = 1'b0;
            #40000 ps2_clk = 1'b1;
        end
        #40000 ps2_data = 1'b1;
    endtask
    initial begin
        int s0, e0, r0, q0, f0;
        v = '{
            '{8'h1C, 1'b0, 1, 8'h1C, 1'b0, 1'b0, 0, 0, 1},
            '{8'hF0, 1'b0, 0, 8'h1C, 1'b0, 1'b0, 0, 0, 1},
            '{8'h1C, 1'b0, 1, 8'h1C, 1'b1, 1'b0, 0, 0, 1},
            '{8'hE0, 1'b0, 0, 8'h1C, 1'b1, 1'b0, 0, 0, 1},
            '{8'hF0, 1'b0, 0, 8'h1C, 1'b1, 1'b0, 0, 0, 1},
            '{8'h75, 1'b0, 1, 8'h75, 1'b1, 1'b1, 0, 0, 1},
            '{8'h29, 1'b1, 0, 8'h75, 1'b1, 1'b1, 1, 1, 0},
            '{8'h32, 1'b0, 1, 8'h32, 1'b0, 1'b0, 0, 1, 1}
        };
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data", 0, m_data, 0);
        chk("rst_pulses", 0, {m_strb, m_err}, 0);
        chk("rst_flags", 0, {m_brk, m_ext}, 0);
        chk("rst_code", 0, m_code, 0);
        #20000;
        for (int i = 0; i < 8; i++) begin
            s0 = ms; e0 = me; r0 = rs; q0 = re;
            send(v[i].d, v[i].pbad, 11, 1'b0);
            #20000;
            chk("strb_cnt", i, ms - s0, v[i].ms);
            chk("data", i, m_data, v[i].md);
            chk("break", i, m_brk, v[i].mb);
            chk("ext", i, m_ext, v[i].me);
            chk("err_cnt", i, me - e0, v[i].merr);
            chk("err_code", i, m_code, v[i].mcode);
            chk("raw_strb_cnt", i, rs - r0, v[i].rs);
            chk("raw_err_cnt", i, re - q0, v[i].merr);
            chk("raw_flags", i, {r_brk, r_ext}, 0);
            if (v[i].rs != 0) chk("raw_data", i, r_data, v[i].d);
        end
        s0 = ms; e0 = me; f0 = fe;
        send(8'h5A, 1'b0, 11, 1'b1);
        #20000;
        chk("glitch_strb", 0, ms - s0, 1);
        chk("glitch_data", 0, m_data, 8'h5A);
        chk("glitch_err", 0, me - e0, 0);
        #400000;
        chk("f2_glitch_err", 0, int'(fe - f0 > 0), 1);
        s0 = ms; e0 = me;
        send(8'h21, 1'b0, 5, 1'b0);
        #250000;
        chk("to_err", 0, me - e0, 1);
        chk("to_code", 0, m_code, 3);
        chk("to_strb", 0, ms - s0, 0);
        send(8'h21, 1'b0, 11, 1'b0);
        #20000;
        chk("after_to_strb", 0, ms - s0, 1);
        chk("after_to_data", 0, m_data, 8'h21);
        send(8'hF0, 1'b0, 11, 1'b0);
        #20000;
        send(8'h1C, 1'b0, 7, 1'b0);
        s0 = ms; e0 = me;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("mid_rst_data", 0, m_data, 0);
        chk("mid_rst_code", 0, m_code, 0);
        #100000;
        chk("mid_rst_err", 0, me - e0, 0);
        chk("mid_rst_strb", 0, ms - s0, 0);
        send(8'h1C, 1'b0, 11, 1'b0);
        #20000;
        chk("post_rst_strb", 0, ms - s0, 1);
        chk("post_rst_data", 0, m_data, 8'h1C);
        chk("post_rst_flags", 0, {m_brk, m_ext}, 0);
        chk("exclusive", 0, both, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
